// File: rtl/gray_code_counter.sv
// Gray-code sequence generator with a valid/ready output handshake, up/down stepping,
// synchronous load and a wrap pulse. Define GRAY_CHECK_EN to build the sticky adjacency checker.
//
// state    | meaning
// ST_IDLE  | no code offered (g_valid_o=0), waiting for en_i
// ST_VALID | g_out_o offered downstream, held until accepted
module gray_code_counter #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_bin_i,
  output logic [WIDTH-1:0] g_out_o,
  output logic             g_valid_o,
  input  logic             g_ready_i,
  output logic             tc_o,
  output logic             err_o
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] g_out_q, g_out_d;
  logic             tc_q, tc_d;
  logic             accept;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign accept = (state_q == ST_VALID) & g_ready_i;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    tc_d    = 1'b0;
    // A load wins over a simultaneous accept: the offered code is consumed, no step taken.
    if (load_i) begin
      bin_d   = load_bin_i;
      state_d = en_i ? ST_VALID : ST_IDLE;
    end else if (accept) begin
      if (up_dn_i) begin
        bin_d = bin_q + WIDTH'(1);
        tc_d  = &bin_q;
      end else begin
        bin_d = bin_q - WIDTH'(1);
        tc_d  = ~|bin_q;
      end
      state_d = en_i ? ST_VALID : ST_IDLE;
    end else if ((state_q == ST_IDLE) && en_i) begin
      state_d = ST_VALID;
    end
    g_out_d = to_gray(bin_d);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      bin_q   <= INIT;
      g_out_q <= to_gray(INIT);
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      g_out_q <= g_out_d;
      tc_q    <= tc_d;
    end
  end

  assign g_out_o   = g_out_q;
  assign g_valid_o = (state_q == ST_VALID);
  assign tc_o      = tc_q;

`ifdef GRAY_CHECK_EN
  logic err_q;
  logic step_accept;

  function automatic int hamming(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  assign step_accept = accept & ~load_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if (step_accept && (hamming(g_out_d ^ g_out_q) != 1)) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (g_valid_o && !g_ready_i && !load_i) |=> $stable(g_out_o));
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter: an arithmetic reference model checked every cycle,
// plus literal expectations on the reset, up-run, backpressure, wrap, load and reset cases.
`timescale 1ns/100ps
module tb_gray_code_counter;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       en_i, up_dn_i, load_i, g_ready_i;
  logic [3:0] load_bin_i;
  logic [3:0] g_out_o;
  logic       g_valid_o, tc_o, err_o;

  int checks = 0;
  int errors = 0;

  int m_bin   = 0;
  bit m_valid = 0;
  bit m_tc    = 0;

  gray_code_counter #(.WIDTH(4), .INIT(4'd0)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .en_i       (en_i),
    .up_dn_i    (up_dn_i),
    .load_i     (load_i),
    .load_bin_i (load_bin_i),
    .g_out_o    (g_out_o),
    .g_valid_o  (g_valid_o),
    .g_ready_i  (g_ready_i),
    .tc_o       (tc_o),
    .err_o      (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: binary count as an integer mod 16; Gray derived arithmetically.
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_bin   = 0;
      m_valid = 0;
      m_tc    = 0;
    end else begin
      bit acc;
      acc  = m_valid && g_ready_i;
      m_tc = 0;
      if (load_i) begin
        m_bin   = int'(load_bin_i);
        m_valid = en_i;
      end else if (acc) begin
        if (up_dn_i) begin
          m_tc  = (m_bin == 15);
          m_bin = (m_bin + 1) % 16;
        end else begin
          m_tc  = (m_bin == 0);
          m_bin = (m_bin + 15) % 16;
        end
        m_valid = en_i;
      end else if (en_i) begin
        m_valid = 1;
      end
    end
  end

  always @(posedge clk_i) begin
    #1;
    if (rst_n_i) begin
      chk("model_g_out", int'(g_out_o), m_bin ^ (m_bin >> 1));
      chk("model_valid", int'(g_valid_o), int'(m_valid));
      chk("model_tc",    int'(tc_o), int'(m_tc));
      chk("model_err",   int'(err_o), 0);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  int up_tbl [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                      4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    int tc_seen;
    rst_n_i = 1'b0; en_i = 0; up_dn_i = 1; load_i = 0; g_ready_i = 0; load_bin_i = 0;

    // 1. reset with random inputs
    for (int i = 0; i < 4; i++) begin
      en_i = 1'($urandom); up_dn_i = 1'($urandom); load_i = 1'($urandom);
      g_ready_i = 1'($urandom); load_bin_i = 4'($urandom);
      tick();
      chk("rst_g_out", int'(g_out_o), 0);
      chk("rst_valid", int'(g_valid_o), 0);
      chk("rst_tc", int'(tc_o), 0);
      chk("rst_err", int'(err_o), 0);
    end
    en_i = 0; up_dn_i = 1; load_i = 0; g_ready_i = 0; load_bin_i = 0;
    rst_n_i = 1'b1;
    tick();
    chk("idle_valid", int'(g_valid_o), 0);

    // 2. up run, 17 accepts
    en_i = 1; up_dn_i = 1; g_ready_i = 1;
    tick();
    tc_seen = 0;
    for (int i = 0; i < 17; i++) begin
      chk("up_seq", int'(g_out_o), up_tbl[i]);
      chk("up_valid", int'(g_valid_o), 1);
      tick();
      tc_seen += int'(tc_o);
      if (i == 15) chk("up_wrap_tc", int'(tc_o), 1);
    end
    chk("up_tc_count", tc_seen, 1);
    g_ready_i = 0;

    // 3. backpressure holding 0011
    load_i = 1; load_bin_i = 4'd2;
    tick();
    load_i = 0;
    for (int i = 0; i < 5; i++) begin
      en_i = i[0];
      tick();
      chk("bp_hold", int'(g_out_o), 4'b0011);
      chk("bp_valid", int'(g_valid_o), 1);
    end
    en_i = 1; g_ready_i = 1;
    tick();
    chk("bp_release", int'(g_out_o), 4'b0010);
    g_ready_i = 0;

    // 4. down wrap
    load_i = 1; load_bin_i = 4'd0; up_dn_i = 0;
    tick();
    chk("dn_load_g", int'(g_out_o), 4'b0000);
    chk("dn_load_tc", int'(tc_o), 0);
    load_i = 0; g_ready_i = 1;
    tick();
    chk("dn_wrap_g", int'(g_out_o), 4'b1000);
    chk("dn_wrap_tc", int'(tc_o), 1);
    g_ready_i = 0;

    // 5. load coincident with accept
    up_dn_i = 1; load_i = 1; load_bin_i = 4'd4;
    tick();
    chk("la_pre", int'(g_out_o), 4'b0110);
    g_ready_i = 1; load_bin_i = 4'b1010;
    tick();
    chk("la_g", int'(g_out_o), 4'b1111);
    chk("la_tc", int'(tc_o), 0);
    load_i = 0; g_ready_i = 0;
    tick();
    chk("la_nostep", int'(g_out_o), 4'b1111);

    // 6. mid-run reset during an accept
    g_ready_i = 1;
    tick();
    tick();
    #1 rst_n_i = 1'b0;
    #0.5;
    chk("mrst_g", int'(g_out_o), 0);
    chk("mrst_valid", int'(g_valid_o), 0);
    chk("mrst_tc", int'(tc_o), 0);
    #0.5 rst_n_i = 1'b1;
    tick();
    chk("restart_g", int'(g_out_o), 4'b0000);
    chk("restart_valid", int'(g_valid_o), 1);
    tick();
    chk("restart_next", int'(g_out_o), 4'b0001);
    chk("final_err", int'(err_o), 0);

    g_ready_i = 0; en_i = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
